// File: rtl/inert_pkg.sv
// Shared types and command tables for the inertial sensor sequencer.
package inert_pkg;

    typedef enum logic [2:0] {
        WAIT_SETTLE,
        INIT_WR,
        INIT_WT,
        IDLE,
        RD_ISSUE,
        RD_WT,
        VALID
    } inert_state_t;

    typedef logic [15:0] inert_cmd_t;

    localparam inert_cmd_t INIT_CMD [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

    // Order matters: staging byte idx lands in {b1,b0} = pitch, {b3,b2} = AZ
    localparam inert_cmd_t RD_CMD [4]   = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

endpackage

// File: rtl/inert_sync2.sv
// Two-flop synchronizer for an asynchronous level input; 2 cycles of latency.
module inert_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/inertial_sequencer.sv
// Settles, configures the inertial sensor over SPI, then reads pitch rate / AZ on each data-ready.
// Optional transaction watchdog with sticky err is enabled by defining INERT_WDOG_EN.
module inertial_sequencer #(
    parameter int INIT_WAIT_W = 16,
    parameter int WDOG_W      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        init_done,
    output logic        err
);
    import inert_pkg::*;

    localparam logic [INIT_WAIT_W-1:0] TMR_ONE = 1;

    inert_state_t           r_state;
    inert_state_t           w_state_nxt;
    logic [INIT_WAIT_W-1:0] r_timer;
    logic [INIT_WAIT_W-1:0] w_timer_nxt;
    logic [1:0]             r_idx;
    logic [1:0]             w_idx_nxt;
    logic                   r_wrt;
    logic                   w_wrt_nxt;
    inert_cmd_t             r_cmd;
    inert_cmd_t             w_cmd_nxt;
    logic                   r_vld;
    logic                   w_vld_nxt;
    logic [15:0]            r_ptch;
    logic [15:0]            w_ptch_nxt;
    logic [15:0]            r_az;
    logic [15:0]            w_az_nxt;
    logic                   r_init_done;
    logic                   w_init_done_nxt;
    logic [3:0][7:0]        r_stg;
    logic [3:0][7:0]        w_stg_nxt;
    logic                   w_int_sync;
    logic                   w_timeout;
    logic                   w_unused_rd;

    assign w_unused_rd = &{1'b0, rd_data[15:8]};

    inert_sync2 u_int_sync (
        .clk (clk),
        .rst (rst),
        .i_d (INT),
        .o_q (w_int_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT_SETTLE;
            r_timer     <= '0;
            r_idx       <= '0;
            r_wrt       <= 1'b0;
            r_cmd       <= '0;
            r_vld       <= 1'b0;
            r_ptch      <= '0;
            r_az        <= '0;
            r_init_done <= 1'b0;
            r_stg       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_idx       <= w_idx_nxt;
            r_wrt       <= w_wrt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_vld       <= w_vld_nxt;
            r_ptch      <= w_ptch_nxt;
            r_az        <= w_az_nxt;
            r_init_done <= w_init_done_nxt;
            r_stg       <= w_stg_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_idx_nxt       = r_idx;
        w_wrt_nxt       = 1'b0;
        w_cmd_nxt       = r_cmd;
        w_vld_nxt       = 1'b0;
        w_ptch_nxt      = r_ptch;
        w_az_nxt        = r_az;
        w_init_done_nxt = r_init_done;
        w_stg_nxt       = r_stg;
        case (r_state)
            WAIT_SETTLE: begin
                if (&r_timer) begin
                    w_state_nxt = INIT_WR;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_timer_nxt = r_timer + TMR_ONE;
                end
            end
            INIT_WR: begin
                w_wrt_nxt   = 1'b1;
                w_cmd_nxt   = INIT_CMD[r_idx];
                w_state_nxt = INIT_WT;
            end
            INIT_WT: begin
                if (done) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt     = IDLE;
                        w_init_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = INIT_WR;
                    end
                end else if (w_timeout) begin
                    // Retry the same configuration write
                    w_state_nxt = INIT_WR;
                end
            end
            IDLE: begin
                if (w_int_sync && r_init_done) begin
                    w_state_nxt = RD_ISSUE;
                    w_idx_nxt   = 2'd0;
                end
            end
            RD_ISSUE: begin
                w_wrt_nxt   = 1'b1;
                w_cmd_nxt   = RD_CMD[r_idx];
                w_state_nxt = RD_WT;
            end
            RD_WT: begin
                if (done) begin
                    w_stg_nxt[r_idx] = rd_data[7:0];
                    if (r_idx == 2'd3) begin
                        w_state_nxt = VALID;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = RD_ISSUE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            VALID: begin
                w_ptch_nxt  = {r_stg[1], r_stg[0]};
                w_az_nxt    = {r_stg[3], r_stg[2]};
                w_vld_nxt   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = WAIT_SETTLE;
        endcase
    end

`ifdef INERT_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_ONE = 1;

    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;
    logic              w_in_wait;

    assign w_in_wait = (r_state == INIT_WT) || (r_state == RD_WT);
    assign w_timeout = w_in_wait && !done && (&r_wdog);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wrt_nxt) begin
                r_wdog <= '0;
            end else if (w_in_wait && !(&r_wdog)) begin
                r_wdog <= r_wdog + WDOG_ONE;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic [WDOG_W-1:0] w_unused_wdog;

    assign w_unused_wdog = '0;
    assign w_timeout     = 1'b0;
    assign err           = 1'b0;
`endif

    assign wrt       = r_wrt;
    assign cmd       = r_cmd;
    assign vld       = r_vld;
    assign ptch_rt   = r_ptch;
    assign AZ        = r_az;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_inertial_sequencer.sv
// Directed bench for inertial_sequencer with a small SPI responder and output monitor.
module tb_inertial_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        init_done;
    logic        err;

    always #5 clk = ~clk;

    inertial_sequencer #(.INIT_WAIT_W(4), .WDOG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .INT       (INT),
        .done      (done),
        .rd_data   (rd_data),
        .wrt       (wrt),
        .cmd       (cmd),
        .vld       (vld),
        .ptch_rt   (ptch_rt),
        .AZ        (AZ),
        .init_done (init_done),
        .err       (err)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] cmd_log [$];
    bit          spi_en = 1'b1;
    logic [7:0]  b_pl, b_ph, b_al, b_ah;
    int          last_done_cyc = -100;
    int          gap_bad = 0;
    int          gap_cnt = 0;
    int          vld_cnt = 0;
    int          vld_cyc = 0;
    int          vld_lat = 0;
    int          chg_bad = 0;
    logic [15:0] prev_ptch = '0;
    logic [15:0] prev_az   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model: done 3 cycles after wrt, read data by command
    initial begin
        done    = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (wrt && !rst) begin
                cmd_log.push_back(cmd);
                if (cmd != 16'h0D02 && cmd != 16'hA200) begin
                    gap_cnt++;
                    if (cyc - last_done_cyc != 2) gap_bad++;
                end
                if (spi_en) begin
                    repeat (3) @(negedge clk);
                    case (cmd)
                        16'hA200: rd_data = {8'hE1, b_pl};
                        16'hA300: rd_data = {8'hE2, b_ph};
                        16'hAC00: rd_data = {8'hE3, b_al};
                        16'hAD00: rd_data = {8'hE4, b_ah};
                        default:  rd_data = 16'h5AFF;
                    endcase
                    done          = 1'b1;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst && vld) begin
            vld_cnt++;
            vld_cyc = cyc;
            vld_lat = cyc - last_done_cyc;
        end
        if (!rst && !vld && (ptch_rt !== prev_ptch || AZ !== prev_az)) chg_bad++;
        prev_ptch = ptch_rt;
        prev_az   = AZ;
    end

    task automatic wait_wrt(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wrt && n < 300);
        chk(tag, wrt, 1'b1);
    endtask

    task automatic wait_wrt_cmd(input logic [15:0] c, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wrt && cmd == c) && n < 300);
        chk(tag, (wrt && cmd == c), 1'b1);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, init_done, 1'b1);
    endtask

    task automatic wait_vld(input int target, input string tag);
        int n = 0;
        while (vld_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (vld_cnt >= target), 1'b1);
    endtask

    task automatic chk_init_log(input int base, input string tag);
        chk({tag, "_cnt"}, cmd_log.size() - base, 4);
        if (cmd_log.size() >= base + 4) begin
            chk({tag, "_c0"}, cmd_log[base + 0], 16'h0D02);
            chk({tag, "_c1"}, cmd_log[base + 1], 16'h1053);
            chk({tag, "_c2"}, cmd_log[base + 2], 16'h1150);
            chk({tag, "_c3"}, cmd_log[base + 3], 16'h1460);
        end
    endtask

    initial begin
        int lat;
        int base;
        int v0;
        rst  = 1'b1;
        INT  = 1'b0;
        b_pl = '0; b_ph = '0; b_al = '0; b_ah = '0;
        repeat (3) @(negedge clk);
        chk("rst_wrt", wrt, 1'b0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_vld", vld, 1'b0);
        chk("rst_ptch", ptch_rt, 16'h0000);
        chk("rst_az", AZ, 16'h0000);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_err", err, 1'b0);

        // Settle, then configuration; INT before init_done must be ignored
        base = cmd_log.size();
        rst  = 1'b0;
        wait_wrt("settle_wrt_seen", lat);
        chk("settle_lat", lat, 17);
        INT = 1'b1;
        repeat (4) @(negedge clk);
        INT = 1'b0;
        wait_init("init_done_1");
        chk("init_done_lat", cyc - last_done_cyc, 1);
        chk_init_log(base, "init1");
        repeat (20) @(negedge clk);
        chk("no_early_read", cmd_log.size() - base, 4);

        // Single read sequence
        b_pl = 8'h34; b_ph = 8'h12; b_al = 8'hCD; b_ah = 8'hAB;
        base = cmd_log.size();
        v0   = vld_cnt;
        INT  = 1'b1;
        wait_wrt("rd1_wrt_seen", lat);
        INT = 1'b0;
        wait_vld(v0 + 1, "rd1_vld");
        chk("rd1_ptch", ptch_rt, 16'h1234);
        chk("rd1_az", AZ, 16'hABCD);
        chk("rd1_vld_lat", vld_lat, 2);
        chk("rd1_cmd_cnt", cmd_log.size() - base, 4);
        if (cmd_log.size() >= base + 4) begin
            chk("rd1_c0", cmd_log[base + 0], 16'hA200);
            chk("rd1_c1", cmd_log[base + 1], 16'hA300);
            chk("rd1_c2", cmd_log[base + 2], 16'hAC00);
            chk("rd1_c3", cmd_log[base + 3], 16'hAD00);
        end
        repeat (30) @(negedge clk);
        chk("rd1_single_vld", vld_cnt - v0, 1);

        // INT held: two back-to-back sequences
        b_pl = 8'h55; b_ph = 8'h66; b_al = 8'h77; b_ah = 8'h88;
        v0   = vld_cnt;
        INT  = 1'b1;
        wait_vld(v0 + 1, "b2b_vld1");
        chk("b2b_ptch1", ptch_rt, 16'h6655);
        chk("b2b_az1", AZ, 16'h8877);
        b_pl = 8'h99; b_ph = 8'hAA; b_al = 8'hBB; b_ah = 8'hCC;
        wait_wrt("b2b_wrt2_seen", lat);
        chk("b2b_restart_gap", cyc - vld_cyc, 2);
        INT = 1'b0;
        wait_vld(v0 + 2, "b2b_vld2");
        chk("b2b_ptch2", ptch_rt, 16'hAA99);
        chk("b2b_az2", AZ, 16'hCCBB);
        repeat (40) @(negedge clk);
        chk("b2b_vld_count", vld_cnt - v0, 2);

        // Reset during the third read wait
        b_pl = 8'h01; b_ph = 8'h02; b_al = 8'h03; b_ah = 8'h04;
        INT  = 1'b1;
        wait_wrt_cmd(16'hAC00, "abort_rd3_seen");
        @(negedge clk);
        rst = 1'b1;
        INT = 1'b0;
        v0  = vld_cnt;
        repeat (2) @(negedge clk);
        chk("abort_ptch", ptch_rt, 16'h0000);
        chk("abort_az", AZ, 16'h0000);
        chk("abort_init_done", init_done, 1'b0);
        chk("abort_wrt", wrt, 1'b0);
        base = cmd_log.size();
        rst  = 1'b0;
        repeat (3) @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_wrt("reinit_wrt_seen", lat);
        chk("reinit_settle_lat", lat, 11);
        wait_init("init_done_2");
        chk_init_log(base, "init2");
        repeat (20) @(negedge clk);
        chk("abort_no_vld", vld_cnt - v0, 0);
        chk("abort_no_read", cmd_log.size() - base, 4);
        chk("abort_ptch_hold", ptch_rt, 16'h0000);

`ifdef INERT_WDOG_EN
        spi_en = 1'b0;
        v0     = vld_cnt;
        INT    = 1'b1;
        wait_wrt("wdog_wrt_seen", lat);
        INT = 1'b0;
        repeat (20) @(negedge clk);
        chk("wdog_err", err, 1'b1);
        chk("wdog_no_vld", vld_cnt - v0, 0);
        spi_en = 1'b1;
        b_pl = 8'h21; b_ph = 8'h43; b_al = 8'h65; b_ah = 8'h87;
        INT  = 1'b1;
        wait_wrt("wdog_rd_seen", lat);
        INT = 1'b0;
        wait_vld(v0 + 1, "wdog_vld");
        chk("wdog_ptch", ptch_rt, 16'h4321);
        chk("wdog_az", AZ, 16'h8765);
        chk("wdog_err_sticky", err, 1'b1);
`else
        chk("err_tied", err, 1'b0);
`endif

        chk("wrt_after_done_gap", gap_bad, 0);
        chk("gap_samples", (gap_cnt >= 12), 1'b1);
        chk("outputs_stable", chg_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
